// File: rtl/gcd_avalon_pkg.sv
// Shared definitions for the GCD Avalon-MM register slave and its hardware host.
package gcd_avalon_pkg;

    // Register word addresses of the gcd_avalon slave
    localparam logic [1:0] GCD_ADDR_A    = 2'd0;
    localparam logic [1:0] GCD_ADDR_B    = 2'd1;
    localparam logic [1:0] GCD_ADDR_RES  = 2'd2;
    localparam logic [1:0] GCD_ADDR_STAT = 2'd3;

    // Bit of the status register that reports a finished computation
    localparam int GCD_STAT_DONE_BIT = 0;

    // Host sequencing states
    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        POLL_RD,
        POLL_WAIT,
        RES_RD,
        RES_WAIT,
        DONE
    } gcd_host_state_t;

endpackage

// File: rtl/gcd_avalon_host.sv
// Avalon-MM host that feeds operand pairs to gcd_avalon, polls for completion
// and hands the result (or a timeout indication) to a downstream stream.
module gcd_avalon_host
    import gcd_avalon_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int POLL_LIMIT   = 1024
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_timeout,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic [3:0]  avm_byteenable,
    output logic        avm_chipselect
);

    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    gcd_host_state_t   state;
    gcd_host_state_t   state_nxt;
    logic [31:0]       op_b;
    logic [POLL_W-1:0] poll_cnt;
    logic [LAT_W-1:0]  wait_cnt;
    logic              wait_done;
    logic              accept;
    logic              poll_timeout;
    logic              in_wait;

    assign avm_byteenable = 4'hF;

    // Next-state decode; readdata is only trusted on the last wait cycle
    always_comb begin
        state_nxt    = state;
        wait_done    = (wait_cnt == LAT_W'(READ_LATENCY - 1));
        accept       = (state == IDLE) && in_valid;
        poll_timeout = (poll_cnt == POLL_W'(POLL_LIMIT));
        in_wait      = (state == POLL_WAIT) || (state == RES_WAIT);
        unique case (state)
            IDLE:      if (in_valid) state_nxt = WR_A;
            WR_A:      state_nxt = WR_B;
            WR_B:      state_nxt = POLL_RD;
            POLL_RD:   state_nxt = POLL_WAIT;
            POLL_WAIT: begin
                if (wait_done) begin
                    if (avm_readdata[GCD_STAT_DONE_BIT]) begin
                        state_nxt = RES_RD;
                    end else if (poll_timeout) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = POLL_RD;
                    end
                end
            end
            RES_RD:    state_nxt = RES_WAIT;
            RES_WAIT:  if (wait_done) state_nxt = DONE;
            DONE:      if (out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand B latch plus the poll and read-latency counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_b     <= '0;
            poll_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                op_b     <= in_b;
                poll_cnt <= '0;
            end else if (state == POLL_RD) begin
                poll_cnt <= poll_cnt + POLL_W'(1);
            end
            if (in_wait && !wait_done) begin
                wait_cnt <= wait_cnt + LAT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Bus and stream outputs are registered from the upcoming state so each
    // strobe lines up exactly with the cycle its state occupies
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_address    <= GCD_ADDR_A;
            avm_writedata  <= '0;
        end else begin
            in_ready       <= (state_nxt == IDLE);
            out_valid      <= (state_nxt == DONE);
            avm_write      <= (state_nxt == WR_A) || (state_nxt == WR_B);
            avm_read       <= (state_nxt == POLL_RD) || (state_nxt == RES_RD);
            avm_chipselect <= (state_nxt == WR_A) || (state_nxt == WR_B) ||
                              (state_nxt == POLL_RD) || (state_nxt == RES_RD);
            unique case (state_nxt)
                WR_A: begin
                    avm_address   <= GCD_ADDR_A;
                    avm_writedata <= in_a;
                end
                WR_B: begin
                    avm_address   <= GCD_ADDR_B;
                    avm_writedata <= op_b;
                end
                POLL_RD: avm_address <= GCD_ADDR_STAT;
                RES_RD:  avm_address <= GCD_ADDR_RES;
                default: ;
            endcase
        end
    end

    // Result capture: cleared on accept, loaded on the result read or forced to
    // zero with the timeout flag when polling gives up
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_result  <= '0;
            out_timeout <= 1'b0;
        end else if (accept) begin
            out_result  <= '0;
            out_timeout <= 1'b0;
        end else if ((state == RES_WAIT) && wait_done) begin
            out_result <= avm_readdata;
        end else if ((state == POLL_WAIT) && wait_done &&
                     !avm_readdata[GCD_STAT_DONE_BIT] && poll_timeout) begin
            out_result  <= '0;
            out_timeout <= 1'b1;
        end
    end

endmodule
